// File: rtl/okpipe_in_arbiter_if.sv
// Pipe-in arbiter bus: per-channel endpoint write strobes/words in,
// merged valid/ready stream with channel tag and end-of-burst out,
// plus sticky per-channel overflow flags and their clear pulses.
// master = arbiter side, slave = endpoint/core side.
interface okpipe_in_arbiter_if #(
    parameter int unsigned N_CH = 4
);
    logic [N_CH-1:0]    ep_write_in;
    logic [32*N_CH-1:0] ep_data_in;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_data;
    logic [2:0]         out_ch;
    logic               out_last;
    logic [N_CH-1:0]    ovf;
    logic [N_CH-1:0]    ovf_clr;

    modport master (
        input  ep_write_in, ep_data_in, out_ready, ovf_clr,
        output out_valid, out_data, out_ch, out_last, ovf
    );

    modport slave (
        output ep_write_in, ep_data_in, out_ready, ovf_clr,
        input  out_valid, out_data, out_ch, out_last, ovf
    );
endinterface

// File: rtl/okpipe_in_arbiter.sv
// Round-robin merge of N_CH pipe-in endpoint streams into one valid/ready
// stream. Each channel has an elastic FIFO (endpoints cannot be stalled);
// a grant covers min(occupancy, BURST) words sampled at grant time.
// Optional macro PIPE_ARB_HDR_EN: emit one header word before every burst.
module okpipe_in_arbiter #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned BURST = 8
) (
    input logic                 ti_clk,
    input logic                 ti_reset,
    okpipe_in_arbiter_if.master bus
);
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned CHW = $clog2(N_CH);

    typedef logic [AW:0] occ_t;

`ifdef PIPE_ARB_HDR_EN
    typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_BURST} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_BURST} state_t;
`endif

    state_t         state, state_n;
    logic [CHW-1:0] gnt, gnt_n, rr, rr_n, cand;
    logic           found;
    occ_t           len, len_n, cnt, cnt_n;

    logic [31:0]     mem [N_CH][DEPTH];
    occ_t            wr_ptr [N_CH];
    occ_t            rd_ptr [N_CH];
    occ_t            occ [N_CH];
    logic [N_CH-1:0] full, empty, push, pop, drop, ovf_q;

    logic        o_valid, o_last;
    logic [31:0] o_data;
    logic [2:0]  o_ch;

    // Per-channel FIFO status and push/pop/drop decisions; a full FIFO still
    // accepts a write when the arbiter pops it in the same cycle.
    always_comb begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            occ[i]   = wr_ptr[i] - rd_ptr[i];
            full[i]  = (occ[i] == occ_t'(DEPTH));
            empty[i] = (occ[i] == '0);
            pop[i]   = (state == ST_BURST) && bus.out_ready && (gnt == CHW'(i));
            push[i]  = bus.ep_write_in[i] && (!full[i] || pop[i]);
            drop[i]  = bus.ep_write_in[i] && full[i] && !pop[i];
        end
    end

    // FIFO storage writes (contents need no reset; pointers define validity).
    always_ff @(posedge ti_clk) begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i][AW-1:0]] <= bus.ep_data_in[32*i +: 32];
            end
        end
    end

    // FIFO pointers; reset empties every channel and discards any partial burst.
    always_ff @(posedge ti_clk or posedge ti_reset) begin
        if (ti_reset) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
            end
        end
    end

    // Sticky overflow flags; a drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge ti_clk or posedge ti_reset) begin
        if (ti_reset) ovf_q <= '0;
        else          ovf_q <= (ovf_q & ~bus.ovf_clr) | drop;
    end

    // Round-robin search: first non-empty channel after rr, wrapping.
    always_comb begin
        int unsigned idx;
        found = 1'b0;
        cand  = '0;
        idx   = 0;
        for (int unsigned k = 1; k <= N_CH; k++) begin
            idx = 32'(rr) + k;
            if (idx >= N_CH) idx = idx - N_CH;
            if (!found && !empty[CHW'(idx)]) begin
                found = 1'b1;
                cand  = CHW'(idx);
            end
        end
    end

    // FSM state and grant bookkeeping registers.
    always_ff @(posedge ti_clk or posedge ti_reset) begin
        if (ti_reset) begin
            state <= ST_IDLE;
            gnt   <= '0;
            rr    <= CHW'(N_CH - 1);
            len   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            gnt   <= gnt_n;
            rr    <= rr_n;
            len   <= len_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state and output decode; outputs are zero outside an active grant.
    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        rr_n    = rr;
        len_n   = len;
        cnt_n   = cnt;
        o_valid = 1'b0;
        o_data  = '0;
        o_ch    = '0;
        o_last  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (found) begin
                    gnt_n = cand;
                    rr_n  = cand;
                    len_n = (occ[cand] > occ_t'(BURST)) ? occ_t'(BURST) : occ[cand];
                    cnt_n = '0;
`ifdef PIPE_ARB_HDR_EN
                    state_n = ST_HDR;
`else
                    state_n = ST_BURST;
`endif
                end
            end
`ifdef PIPE_ARB_HDR_EN
            ST_HDR: begin
                o_valid = 1'b1;
                o_data  = {8'hA5, 5'b0, 3'(gnt), 16'(len)};
                o_ch    = 3'(gnt);
                if (bus.out_ready) state_n = ST_BURST;
            end
`endif
            ST_BURST: begin
                o_valid = 1'b1;
                o_data  = mem[gnt][rd_ptr[gnt][AW-1:0]];
                o_ch    = 3'(gnt);
                o_last  = (cnt == len - 1'b1);
                if (bus.out_ready) begin
                    cnt_n = cnt + 1'b1;
                    if (o_last) state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign bus.out_valid = o_valid;
    assign bus.out_data  = o_data;
    assign bus.out_ch    = o_ch;
    assign bus.out_last  = o_last;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_okpipe_in_arbiter.sv
// Directed self-checking bench for okpipe_in_arbiter (N_CH=4, DEPTH=16,
// BURST=8). Expectations follow PIPE_ARB_HDR_EN when it is defined.
module tb_okpipe_in_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;
    int   n_fail  = 0;

    okpipe_in_arbiter_if #(.N_CH(4)) b ();

    okpipe_in_arbiter #(.N_CH(4), .DEPTH(16), .BURST(8)) u_dut (
        .ti_clk   (clk),
        .ti_reset (rst),
        .bus      (b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int ch, input logic [31:0] d);
        b.ep_write_in[ch]         = 1'b1;
        b.ep_data_in[32*ch +: 32] = d;
    endtask

    task automatic clr_wr();
        b.ep_write_in = '0;
        b.ep_data_in  = '0;
    endtask

    task automatic expect_beat(input string tag, input logic [31:0] d,
                               input logic [2:0] ch, input logic last);
        chk({tag, "_valid"}, 32'(b.out_valid), 32'd1);
        chk({tag, "_data"},  b.out_data, d);
        chk({tag, "_ch"},    32'(b.out_ch), 32'(ch));
        chk({tag, "_last"},  32'(b.out_last), 32'(last));
        tick();
    endtask

    task automatic expect_idle(input string tag);
        chk({tag, "_idle"}, 32'(b.out_valid), 32'd0);
        tick();
    endtask

    task automatic burst_start(input string tag, input logic [2:0] ch, input int len);
`ifdef PIPE_ARB_HDR_EN
        expect_beat({tag, "_hdr"}, {8'hA5, 5'b0, ch, 16'(len)}, ch, 1'b0);
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr_wr();
        b.ovf_clr   = '0;
        b.out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        b.out_ready = 1'b0;
        b.ovf_clr   = '0;
        clr_wr();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(b.out_valid), 32'd0);
        chk("rst_data",  b.out_data, 32'd0);
        chk("rst_ch",    32'(b.out_ch), 32'd0);
        chk("rst_last",  32'(b.out_last), 32'd0);
        chk("rst_ovf",   32'(b.ovf), 32'd0);
        rst = 1'b0;
        expect_idle("rst_rel");

        // Single word on ch2: grant one edge after the push.
        b.out_ready = 1'b1;
        set_wr(2, 32'h1234_5678);
        tick();
        clr_wr();
        chk("t1_wait", 32'(b.out_valid), 32'd0);
        tick();
        burst_start("t1", 3'd2, 1);
        expect_beat("t1", 32'h1234_5678, 3'd2, 1'b1);
        expect_idle("t1_end");

        // 16 words on ch0 with out_ready=0: first grant sees 1 word, then 8, then 7.
        b.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            set_wr(0, 32'h100 + 32'(i));
            tick();
        end
        clr_wr();
`ifdef PIPE_ARB_HDR_EN
        chk("t2_hold_data", b.out_data, 32'hA500_0001);
        chk("t2_hold_last", 32'(b.out_last), 32'd0);
`else
        chk("t2_hold_data", b.out_data, 32'h100);
        chk("t2_hold_last", 32'(b.out_last), 32'd1);
`endif
        chk("t2_hold_valid", 32'(b.out_valid), 32'd1);
        chk("t2_ovf", 32'(b.ovf), 32'd0);
        b.out_ready = 1'b1;
        burst_start("t2a", 3'd0, 1);
        expect_beat("t2a", 32'h100, 3'd0, 1'b1);
        expect_idle("t2a_gap");
        burst_start("t2b", 3'd0, 8);
        for (int i = 1; i <= 8; i++) expect_beat("t2b", 32'h100 + 32'(i), 3'd0, i == 8);
        expect_idle("t2b_gap");
        burst_start("t2c", 3'd0, 7);
        for (int i = 9; i <= 15; i++) expect_beat("t2c", 32'h100 + 32'(i), 3'd0, i == 15);
        expect_idle("t2_end");

        // Four channels, 3 words each, after reset: ch0 granted first with 1 word.
        do_reset();
        for (int j = 0; j < 3; j++) begin
            for (int c = 0; c < 4; c++) set_wr(c, 32'hC000_0000 | (32'(c) << 8) | 32'(j));
            tick();
        end
        clr_wr();
        b.out_ready = 1'b1;
        burst_start("t3_c0a", 3'd0, 1);
        expect_beat("t3_c0a", 32'hC000_0000, 3'd0, 1'b1);
        expect_idle("t3_gap0");
        for (int c = 1; c < 4; c++) begin
            burst_start("t3_rr", 3'(c), 3);
            for (int j = 0; j < 3; j++)
                expect_beat("t3_rr", 32'hC000_0000 | (32'(c) << 8) | 32'(j), 3'(c), j == 2);
            expect_idle("t3_gap");
        end
        burst_start("t3_c0b", 3'd0, 2);
        expect_beat("t3_c0b", 32'hC000_0001, 3'd0, 1'b0);
        expect_beat("t3_c0b", 32'hC000_0002, 3'd0, 1'b1);
        expect_idle("t3_end");

        // 18 writes on ch1 into a 16-deep FIFO: two dropped, sticky ovf.
        b.out_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            set_wr(1, 32'h1100 + 32'(i));
            b.ovf_clr[1] = (i == 17);
            tick();
        end
        clr_wr();
        b.ovf_clr = '0;
        chk("t4_ovf_set", 32'(b.ovf), 32'h2);
        b.ovf_clr[1] = 1'b1;
        tick();
        b.ovf_clr = '0;
        chk("t4_ovf_clr", 32'(b.ovf), 32'h0);
        b.out_ready = 1'b1;
        burst_start("t4a", 3'd1, 1);
        expect_beat("t4a", 32'h1100, 3'd1, 1'b1);
        expect_idle("t4a_gap");
        burst_start("t4b", 3'd1, 8);
        for (int i = 1; i <= 8; i++) expect_beat("t4b", 32'h1100 + 32'(i), 3'd1, i == 8);
        expect_idle("t4b_gap");
        burst_start("t4c", 3'd1, 7);
        for (int i = 9; i <= 15; i++) expect_beat("t4c", 32'h1100 + 32'(i), 3'd1, i == 15);
        expect_idle("t4_end");
        expect_idle("t4_empty");

        // Full ch2 accepts a write in the same cycle as a pop.
        b.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            set_wr(2, 32'h2200 + 32'(i));
            tick();
        end
        clr_wr();
        b.out_ready = 1'b1;
        burst_start("t5a", 3'd2, 1);
        set_wr(2, 32'h22FF);
        expect_beat("t5a", 32'h2200, 3'd2, 1'b1);
        clr_wr();
        chk("t5_no_ovf", 32'(b.ovf), 32'h0);
        expect_idle("t5a_gap");
        burst_start("t5b", 3'd2, 8);
        for (int i = 1; i <= 8; i++) expect_beat("t5b", 32'h2200 + 32'(i), 3'd2, i == 8);
        expect_idle("t5b_gap");
        burst_start("t5c", 3'd2, 8);
        for (int i = 9; i <= 15; i++) expect_beat("t5c", 32'h2200 + 32'(i), 3'd2, 1'b0);
        expect_beat("t5c", 32'h22FF, 3'd2, 1'b1);
        expect_idle("t5_end");

        // Async reset in the middle of an 8-word burst on ch1.
        b.out_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            set_wr(1, 32'h5500 + 32'(i));
            tick();
        end
        clr_wr();
        b.out_ready = 1'b1;
        burst_start("t6a", 3'd1, 1);
        expect_beat("t6a", 32'h5500, 3'd1, 1'b1);
        expect_idle("t6a_gap");
        burst_start("t6b", 3'd1, 8);
        for (int i = 1; i <= 3; i++) expect_beat("t6b", 32'h5500 + 32'(i), 3'd1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(b.out_valid), 32'd0);
        chk("t6_rst_data",  b.out_data, 32'd0);
        chk("t6_rst_ch",    32'(b.out_ch), 32'd0);
        chk("t6_rst_last",  32'(b.out_last), 32'd0);
        chk("t6_rst_ovf",   32'(b.ovf), 32'd0);
        tick();
        rst = 1'b0;
        expect_idle("t6_flushed0");
        expect_idle("t6_flushed1");
        set_wr(3, 32'h3333);
        set_wr(0, 32'h0A0A);
        tick();
        clr_wr();
        expect_idle("t6_wait");
        burst_start("t6_c0", 3'd0, 1);
        expect_beat("t6_c0", 32'h0A0A, 3'd0, 1'b1);
        expect_idle("t6_gap");
        burst_start("t6_c3", 3'd3, 1);
        expect_beat("t6_c3", 32'h3333, 3'd3, 1'b1);
        expect_idle("t6_end");

        // Words arriving while another grant is held form one 5-word burst on ch3.
        b.out_ready = 1'b0;
        set_wr(0, 32'hAAAA_0000);
        tick();
        clr_wr();
        for (int i = 0; i < 5; i++) begin
            set_wr(3, 32'h3300 + 32'(i));
            tick();
        end
        clr_wr();
        b.out_ready = 1'b1;
        burst_start("t7_c0", 3'd0, 1);
        expect_beat("t7_c0", 32'hAAAA_0000, 3'd0, 1'b1);
        expect_idle("t7_gap");
        burst_start("t7_c3", 3'd3, 5);
        for (int i = 0; i < 5; i++) expect_beat("t7_c3", 32'h3300 + 32'(i), 3'd3, i == 4);
        expect_idle("t7_end");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
